param_transposed_fir: RTL and testbench

Parametrised transposed-form FIR filter, the next generation of the reconfigurable FIR top. It replaces the fixed 33-tap, four-RAM-bank structure with a single generic tap array. It adds double-buffered (shadow/active) coefficients that swap atomically on a sample boundary, a runtime tap count, coefficient readback, and a saturating, scaled output. It sits between the sample source (300 kHz strobe in the 12 MHz domain) and the downstream output register/DAC interface.

---
 rtl/param_transposed_fir_if.sv | 36 +++
 rtl/param_transposed_fir.sv | 134 +++++++++++++
 tb/tb_param_transposed_fir.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_transposed_fir_if.sv
// Sample, coefficient-port and result signals of param_transposed_fir.
//   master: sample source / coefficient loader (drives iX, observes oX)
//   slave : the filter (observes iX, drives oX)
interface param_transposed_fir_if #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned ADDR_W = 6
);
  logic                     iEnSample;
  logic signed [IN_W-1:0]   iFirIn;
  logic                     iCsnRam;
  logic                     iWrnRam;
  logic [ADDR_W-1:0]        iAddrRam;
  logic signed [COEF_W-1:0] iWrDtRam;
  logic                     iCoeffUpdate;
  logic [ADDR_W:0]          iNumOfCoeff;
  logic signed [COEF_W-1:0] oRdDtRam;
  logic signed [OUT_W-1:0]  oFirOut;
  logic                     oValid;
  logic                     oSat;
  logic                     oSwapPending;
  logic                     oSwapDone;

  modport master (
    output iEnSample, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
           iCoeffUpdate, iNumOfCoeff,
    input  oRdDtRam, oFirOut, oValid, oSat, oSwapPending, oSwapDone
  );

  modport slave (
    input  iEnSample, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
           iCoeffUpdate, iNumOfCoeff,
    output oRdDtRam, oFirOut, oValid, oSat, oSwapPending, oSwapDone
  );
endinterface

// File: rtl/param_transposed_fir.sv
// Parametrised transposed-form FIR with shadow/active coefficient banks that
// swap on a sample boundary, runtime tap count, coefficient readback and a
// scaled, saturating output.
//   iClk_12M : system clock
//   iRsn     : asynchronous active-low reset
//   firBus   : sample strobe/data, coefficient port, swap control, results
module param_transposed_fir #(
  parameter int unsigned NUM_TAPS = 33,
  parameter int unsigned IN_W     = 3,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                   iClk_12M,
  input  logic                   iRsn,
  param_transposed_fir_if.slave  firBus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned ACC_W = IN_W + COEF_W + $clog2(NUM_TAPS);
  localparam logic signed [OUT_W-1:0] OUT_MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = ACC_W'(OUT_MAX_V);
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = ACC_W'(OUT_MIN_V);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swapState_t;

  logic signed [COEF_W-1:0] shadowQ [NUM_TAPS];
  logic signed [COEF_W-1:0] activeQ [NUM_TAPS];
  // zQ[j] holds z[j+1]
  logic signed [ACC_W-1:0]  zQ      [NUM_TAPS-1];
  logic signed [ACC_W-1:0]  prod    [NUM_TAPS];
  logic [CNT_W-1:0]         nActQ;
  swapState_t               stateQ, stateD;
  logic                     swapEn;

  logic signed [ACC_W-1:0]  xExt, cExt, acc, accSh;
  logic signed [OUT_W-1:0]  satVal;
  logic                     clip;
  logic                     addrOk;

  assign addrOk = {1'b0, firBus.iAddrRam} < CNT_W'(NUM_TAPS);

  // Swap FSM state register
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Swap FSM next state; swap fires on the first strobe while pending
  always_comb begin
    stateD = stateQ;
    swapEn = 1'b0;
    case (stateQ)
      IDLE:    if (firBus.iCoeffUpdate) stateD = PENDING;
      PENDING: if (firBus.iEnSample) begin
                 stateD = IDLE;
                 swapEn = 1'b1;
               end
      default: stateD = IDLE;
    endcase
  end

  // Tap products with taps at or beyond nAct forced to zero
  always_comb begin
    xExt = ACC_W'(firBus.iFirIn);
    cExt = '0;
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      cExt    = (CNT_W'(k) < nActQ) ? ACC_W'(activeQ[k]) : '0;
      prod[k] = xExt * cExt;
    end
  end

  // Output accumulate, scale and clamp
  always_comb begin
    acc    = prod[0] + zQ[0];
    accSh  = acc >>> SHIFT;
    satVal = OUT_W'(accSh);
    clip   = 1'b0;
    if (accSh > OUT_MAX_A) begin
      satVal = OUT_MAX_V;
      clip   = 1'b1;
    end else if (accSh < OUT_MIN_A) begin
      satVal = OUT_MIN_V;
      clip   = 1'b1;
    end
  end

  // Coefficient banks and readback; active samples shadow before any same-edge write
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        shadowQ[k] <= '0;
        activeQ[k] <= '0;
      end
      nActQ           <= CNT_W'(NUM_TAPS);
      firBus.oRdDtRam <= '0;
    end else begin
      if (!firBus.iCsnRam && !firBus.iWrnRam && addrOk)
        shadowQ[firBus.iAddrRam] <= firBus.iWrDtRam;
      if (!firBus.iCsnRam && firBus.iWrnRam)
        firBus.oRdDtRam <= addrOk ? shadowQ[firBus.iAddrRam] : '0;
      if (swapEn) begin
        for (int k = 0; k < int'(NUM_TAPS); k++) activeQ[k] <= shadowQ[k];
        nActQ <= (firBus.iNumOfCoeff > CNT_W'(NUM_TAPS)) ? CNT_W'(NUM_TAPS)
                                                         : firBus.iNumOfCoeff;
      end
    end
  end

  // Transposed delay line and registered results
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int j = 0; j < int'(NUM_TAPS) - 1; j++) zQ[j] <= '0;
      firBus.oFirOut      <= '0;
      firBus.oSat         <= 1'b0;
      firBus.oValid       <= 1'b0;
      firBus.oSwapPending <= 1'b0;
      firBus.oSwapDone    <= 1'b0;
    end else begin
      firBus.oValid       <= firBus.iEnSample;
      firBus.oSwapPending <= (stateD == PENDING);
      firBus.oSwapDone    <= swapEn;
      if (firBus.iEnSample) begin
        for (int j = 0; j < int'(NUM_TAPS) - 2; j++) zQ[j] <= prod[j+1] + zQ[j+1];
        zQ[NUM_TAPS-2] <= prod[NUM_TAPS-1];
        firBus.oFirOut <= satVal;
        firBus.oSat    <= clip;
      end
    end
  end

endmodule

// File: tb/tb_param_transposed_fir.sv
// Directed self-checking bench for param_transposed_fir.
`timescale 1ns/1ps
module tb_param_transposed_fir;

  localparam int unsigned NUM_TAPS = 33;
  localparam int unsigned IN_W     = 3;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned SHIFT    = 0;
  localparam int unsigned ADDR_W   = 6;

  logic iClk_12M = 1'b0;
  logic iRsn;
  always #5 iClk_12M = ~iClk_12M;

  param_transposed_fir_if #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) firBus ();

  param_transposed_fir #(
    .NUM_TAPS(NUM_TAPS), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
    .SHIFT(SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .iClk_12M(iClk_12M),
    .iRsn    (iRsn),
    .firBus  (firBus)
  );

  int tests = 0;
  int fails = 0;
  logic signed [OUT_W-1:0]  gOut;
  logic                     gValid, gSat, gDone;
  logic signed [COEF_W-1:0] gRd;

  task automatic tick();
    @(posedge iClk_12M);
    #1;
  endtask

  task automatic writeCoef(input int addr, input int data);
    firBus.iCsnRam  = 1'b0;
    firBus.iWrnRam  = 1'b0;
    firBus.iAddrRam = ADDR_W'(addr);
    firBus.iWrDtRam = COEF_W'(data);
    tick();
    firBus.iCsnRam  = 1'b1;
  endtask

  task automatic readCoef(input int addr);
    firBus.iCsnRam  = 1'b0;
    firBus.iWrnRam  = 1'b1;
    firBus.iAddrRam = ADDR_W'(addr);
    tick();
    firBus.iCsnRam  = 1'b1;
    gRd = firBus.oRdDtRam;
  endtask

  task automatic loadAll(input int data);
    for (int k = 0; k < int'(NUM_TAPS); k++) writeCoef(k, data);
  endtask

  task automatic sample(input int x);
    firBus.iFirIn    = IN_W'(x);
    firBus.iEnSample = 1'b1;
    tick();
    firBus.iEnSample = 1'b0;
    gOut   = firBus.oFirOut;
    gValid = firBus.oValid;
    gSat   = firBus.oSat;
    gDone  = firBus.oSwapDone;
  endtask

  task automatic requestSwap(input int num);
    firBus.iNumOfCoeff  = (ADDR_W+1)'(num);
    firBus.iCoeffUpdate = 1'b1;
    tick();
    firBus.iCoeffUpdate = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (firBus.oFirOut !== '0) begin fails++; $display("FAIL reset_out: got %0d want 0", firBus.oFirOut); end
    tests++; if (firBus.oValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", firBus.oValid); end
    tests++; if (firBus.oSat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", firBus.oSat); end
    tests++; if (firBus.oSwapPending !== 1'b0 || firBus.oSwapDone !== 1'b0) begin
      fails++; $display("FAIL reset_swap: pending %b done %b want 0 0", firBus.oSwapPending, firBus.oSwapDone); end
    tests++; if (firBus.oRdDtRam !== '0) begin fails++; $display("FAIL reset_rd: got %0h want 0", firBus.oRdDtRam); end
  endtask

  task automatic test_impulse();
    int bad;
    for (int k = 0; k < int'(NUM_TAPS); k++) writeCoef(k, k + 1);
    requestSwap(33);
    tests++; if (firBus.oSwapPending !== 1'b1) begin fails++; $display("FAIL imp_pending: got %b want 1", firBus.oSwapPending); end
    sample(0);
    tests++; if (gDone !== 1'b1 || firBus.oSwapPending !== 1'b0) begin
      fails++; $display("FAIL imp_swapdone: done %b pending %b want 1 0", gDone, firBus.oSwapPending); end
    bad = 0;
    for (int n = 0; n < int'(NUM_TAPS); n++) begin
      sample(n == 0 ? 1 : 0);
      if (gOut !== OUT_W'(n + 1) || gValid !== 1'b1) begin
        bad++; $display("FAIL imp_resp[%0d]: got %0d valid %b want %0d valid 1", n, gOut, gValid, n + 1);
      end
    end
    tests++; if (bad != 0) fails++;
    sample(0);
    tests++; if (gOut !== '0) begin fails++; $display("FAIL imp_tail: got %0d want 0", gOut); end
    tick();
    tests++; if (firBus.oValid !== 1'b0 || firBus.oFirOut !== '0) begin
      fails++; $display("FAIL idle_hold: valid %b out %0d want 0 0", firBus.oValid, firBus.oFirOut); end
  endtask

  task automatic test_swap_boundary();
    int doneCnt;
    loadAll(1);
    requestSwap(33);
    sample(0);
    for (int n = 0; n < 40; n++) sample(1);
    tests++; if (gOut !== OUT_W'(33)) begin fails++; $display("FAIL sb_steady: got %0d want 33", gOut); end
    loadAll(2);
    requestSwap(33);
    doneCnt = 0;
    sample(1);
    if (gDone) doneCnt++;
    tests++; if (gOut !== OUT_W'(33)) begin fails++; $display("FAIL sb_old_coef: got %0d want 33", gOut); end
    sample(1);
    if (gDone) doneCnt++;
    tests++; if (gOut !== OUT_W'(34)) begin fails++; $display("FAIL sb_ramp1: got %0d want 34", gOut); end
    for (int j = 2; j <= 34; j++) begin
      sample(1);
      if (gDone) doneCnt++;
    end
    tests++; if (gOut !== OUT_W'(66)) begin fails++; $display("FAIL sb_final: got %0d want 66", gOut); end
    tests++; if (doneCnt != 1) begin fails++; $display("FAIL sb_done_count: got %0d want 1", doneCnt); end
  endtask

  task automatic test_tap_count();
    loadAll(1);
    requestSwap(5);
    sample(3);
    for (int n = 0; n < 40; n++) sample(3);
    tests++; if (gOut !== OUT_W'(15)) begin fails++; $display("FAIL taps5: got %0d want 15", gOut); end
    requestSwap(40);
    sample(3);
    for (int n = 0; n < 40; n++) sample(3);
    tests++; if (gOut !== OUT_W'(99)) begin fails++; $display("FAIL taps_clamp: got %0d want 99", gOut); end
  endtask

  task automatic test_saturation();
    loadAll(0);
    writeCoef(0, 32767);
    requestSwap(33);
    sample(0);
    for (int n = 0; n < 33; n++) sample(0);
    tests++; if (gOut !== '0 || gSat !== 1'b0) begin fails++; $display("FAIL sat_flush: got %0d sat %b want 0 0", gOut, gSat); end
    sample(-4);
    tests++; if (gOut !== OUT_W'(-32768) || gSat !== 1'b1) begin
      fails++; $display("FAIL sat_neg: got %0d sat %b want -32768 1", gOut, gSat); end
    sample(3);
    tests++; if (gOut !== OUT_W'(32767) || gSat !== 1'b1) begin
      fails++; $display("FAIL sat_pos: got %0d sat %b want 32767 1", gOut, gSat); end
    sample(1);
    tests++; if (gOut !== OUT_W'(32767) || gSat !== 1'b0) begin
      fails++; $display("FAIL sat_edge: got %0d sat %b want 32767 0", gOut, gSat); end
  endtask

  task automatic test_readback();
    writeCoef(7, 16'h1234);
    readCoef(7);
    tests++; if (gRd !== 16'h1234) begin fails++; $display("FAIL rd_addr7: got %0h want 1234", gRd); end
    firBus.iWrnRam  = 1'b1;
    firBus.iAddrRam = '0;
    tick();
    tests++; if (firBus.oRdDtRam !== 16'h1234) begin fails++; $display("FAIL rd_hold: got %0h want 1234", firBus.oRdDtRam); end
    writeCoef(40, 16'h5555);
    readCoef(40);
    tests++; if (gRd !== '0) begin fails++; $display("FAIL rd_oob: got %0h want 0", gRd); end
    sample(1);
    tests++; if (gOut !== OUT_W'(32767)) begin fails++; $display("FAIL rd_act0: got %0d want 32767", gOut); end
    for (int n = 0; n < 7; n++) sample(0);
    tests++; if (gOut !== '0) begin fails++; $display("FAIL rd_active_unchanged: got %0d want 0", gOut); end
  endtask

  task automatic test_reset_midstream();
    int bad;
    requestSwap(33);
    sample(1);
    sample(1);
    tests++; if (gOut !== OUT_W'(32767)) begin fails++; $display("FAIL mid_pre: got %0d want 32767", gOut); end
    readCoef(7);
    requestSwap(33);
    tests++; if (firBus.oSwapPending !== 1'b1 || firBus.oRdDtRam !== 16'h1234) begin
      fails++; $display("FAIL mid_pending: pending %b rd %0h want 1 1234", firBus.oSwapPending, firBus.oRdDtRam); end
    #2 iRsn = 1'b0;
    #1;
    tests++; if (firBus.oFirOut !== '0 || firBus.oRdDtRam !== '0 || firBus.oSwapPending !== 1'b0 ||
                 firBus.oValid !== 1'b0 || firBus.oSat !== 1'b0 || firBus.oSwapDone !== 1'b0) begin
      fails++; $display("FAIL mid_async_reset: out %0d rd %0h pend %b valid %b sat %b done %b want all 0",
                        firBus.oFirOut, firBus.oRdDtRam, firBus.oSwapPending, firBus.oValid, firBus.oSat, firBus.oSwapDone); end
    @(negedge iClk_12M);
    iRsn = 1'b1;
    tick();
    bad = 0;
    for (int n = 0; n < 35; n++) begin
      sample(n == 0 ? 1 : 0);
      if (gOut !== '0 || firBus.oSwapPending !== 1'b0 || gDone !== 1'b0) begin
        bad++; $display("FAIL mid_after[%0d]: out %0d pend %b done %b want 0 0 0", n, gOut, firBus.oSwapPending, gDone);
      end
    end
    tests++; if (bad != 0) fails++;
    readCoef(7);
    tests++; if (gRd !== '0) begin fails++; $display("FAIL mid_shadow_cleared: got %0h want 0", gRd); end
  endtask

  initial begin
    iRsn                = 1'b0;
    firBus.iEnSample    = 1'b0;
    firBus.iFirIn       = '0;
    firBus.iCsnRam      = 1'b1;
    firBus.iWrnRam      = 1'b1;
    firBus.iAddrRam     = '0;
    firBus.iWrDtRam     = '0;
    firBus.iCoeffUpdate = 1'b0;
    firBus.iNumOfCoeff  = 7'd33;
    #22 iRsn = 1'b1;
    tick();
    test_reset();
    test_impulse();
    test_swap_boundary();
    test_tap_count();
    test_saturation();
    test_readback();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
